arm_decode_stage: RTL
=====================

// Module: arm_decode_stage
// PURPOSE
//  Decode stage directly upstream of the operand-2 shifter.
//  Accepts 32-bit ARM instructions from fetch (valid/ready) and splits them into the shifter/ALU field set.
//  Holds RAW hazards with a register scoreboard and registers one decoded instruction for execute.
// PARAMETERS
//  NUM_REGS     16  architectural registers tracked; R15 (PC) is never scoreboarded
//  STALL_CNT_W  16  width of the saturating hazard-stall counter
// PORTS
//  clk              in   1   single clock; all state updates on posedge
//  reset            in   1   synchronous, active-high
//  instr_in         in   32  instruction from fetch
//  instr_valid      in   1   instr_in is valid
//  instr_ready      out  1   stage accepts instr_in this cycle
//  flush            in   1   drop the held and incoming instruction (branch taken)
//  wb_valid         in   1   writeback retiring a register write
//  wb_addr          in   4   register being written back
//  out_valid        out  1   decoded fields below are valid
//  out_ready        in   1   execute consumes the fields this cycle
//  cond             out  4   instr[31:28]
//  opcode           out  5   DP: {0,instr[24:21]}; LDR/STR: 5'b10000; B/BL: 5'b11000; else 5'b11111
//  immediateOperand out  1   DP: instr[25]; LDR/STR: ~instr[25]
//  shiftType        out  2   instr[6:5]
//  rotateVal        out  4   instr[11:8]
//  rm_shift         out  5   instr[11:7]
//  immediateVal     out  8   instr[7:0]
//  immediateOffset  out  12  instr[11:0]
//  rm_shiftSDT      out  8   instr[11:4]
//  rn_addr/rd_addr/rm_addr out 4 each  instr[19:16] / [15:12] / [3:0]
//  set_flags        out  1   DP: instr[20]; else 0
//  is_load          out  1   LDR/STR and instr[20]
//  reg_write        out  1   DP except TST/TEQ/CMP/CMN, LDR, or BL (rd=14); else 0
//  stall_cycles     out  STALL_CNT_W  cycles with instr_valid=1 held back by a hazard, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, all field outputs=0, scoreboard=0, stall_cycles=0; instr_ready=0 during reset.
//  - Class select: instr[27:26]=00 -> DP; 01 -> LDR/STR; 101 in [27:25] -> branch; else undefined (opcode 5'b11111, reg_write 0).
//  - Sources: rn always except MOV/MVN/branch; rm when DP with I=0, or LDR/STR with instr[25]=1; rd for STR.
//  - hazard = any used source (excluding R15) has its scoreboard bit set.
//  - slot_free = ~out_valid | out_ready.
//  - instr_ready = slot_free & ~hazard & ~flush.
//  - Issue when instr_valid & instr_ready: all fields registered next cycle, out_valid=1. Latency is 1 cycle.
//  - Issue with reg_write=1 and dest!=15 sets scoreboard[dest]. BL sets scoreboard[14].
//  - Held output is stable while out_valid & ~out_ready. out_valid clears when out_ready=1 and no new issue.
//  - wb_valid clears scoreboard[wb_addr]. If a same-cycle issue sets the same bit, the set wins.
//  - A hazard resolves on the cycle after wb_valid; no same-cycle bypass.
//  - flush: out_valid=0 next cycle, no issue that cycle. The scoreboard is kept: issued instructions still write back.
//  - stall_cycles increments when instr_valid & slot_free & hazard & ~flush, and saturates at all-ones.
//  - Reset mid-operation discards the held instruction and all pending scoreboard bits.
// STRUCTURE
//  - Shared package/header: opcode class constants (OP_LDST=5'b10000, OP_BRANCH=5'b11000, OP_UNDEF=5'b11111), DP opcode names, shift-type constants.
//  - Sub-module arm_scoreboard: NUM_REGS-bit set/clear register with the set-wins rule and a 3-port read for hazard check.
//  - Decode field extraction stays combinational in this module.
// TESTING
//  - Reset then ADD r1,r2,r3 (0xE0821003): out_valid=1 one cycle later, opcode=5'b00100, immediateOperand=0, rd=1, reg_write=1, scoreboard[1]=1.
//  - ADD r1,... then SUB r4,r1,#1 back-to-back: second held (instr_ready=0), stall_cycles counts; wb_valid wb_addr=1 -> SUB issues the next cycle.
//  - out_ready=0 for 3 cycles with a held instr: outputs unchanged, instr_ready=0; out_ready=1 -> the next instr issues the same cycle.
//  - wb_valid wb_addr=5 in the same cycle as issuing a MOV r5,#7 (0xE3A05007): scoreboard[5] ends at 1.
//  - LDR r0,[r1,#4] (0xE5910004): opcode=5'b10000, is_load=1, immediateOperand=1, immediateOffset=12'h004; flush while held -> out_valid=0, scoreboard[0] stays 1.
//  - Reset asserted with scoreboard bits set and out_valid=1: next cycle everything is 0; 2^STALL_CNT_W+5 hazard cycles -> stall_cycles=all-ones.

Source files
------------

// File: rtl/arm_decode_pkg.sv
// Shared decode constants and types for the ARM decode stage.
// Covers opcode classes, DP opcode names, shift types and the registered field bundle.
package arm_decode_pkg;

    localparam logic [4:0] OP_LDST   = 5'b10000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_UNDEF  = 5'b11111;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [3:0] {
        DP_AND, DP_EOR, DP_SUB, DP_RSB, DP_ADD, DP_ADC, DP_SBC, DP_RSC,
        DP_TST, DP_TEQ, DP_CMP, DP_CMN, DP_ORR, DP_MOV, DP_BIC, DP_MVN
    } dp_op_e;

    typedef enum logic [1:0] {
        CLS_DP, CLS_LDST, CLS_BRANCH, CLS_UNDEF
    } instr_class_e;

    typedef struct packed {
        logic [3:0]  cond;
        logic [4:0]  opcode;
        logic        imm_op;
        logic [1:0]  shift_type;
        logic [3:0]  rotate_val;
        logic [4:0]  rm_shift;
        logic [7:0]  imm_val;
        logic [11:0] imm_off;
        logic [7:0]  rm_shift_sdt;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic        set_flags;
        logic        is_load;
        logic        reg_write;
    } dec_fields_t;

    function automatic instr_class_e classify(input logic [31:0] instr);
        if (instr[27:26] == 2'b00)       return CLS_DP;
        else if (instr[27:26] == 2'b01)  return CLS_LDST;
        else if (instr[27:25] == 3'b101) return CLS_BRANCH;
        else                             return CLS_UNDEF;
    endfunction

endpackage

// File: rtl/arm_decode_stage_scoreboard.sv
// Register-busy scoreboard: one pending-write bit per architectural register.
// A same-cycle set and clear of one bit resolves to set.
module arm_scoreboard
    import arm_decode_pkg::*;
#(
    parameter int NUM_REGS = 16,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                set_en_i,
    input  logic [AW-1:0]       set_addr_i,
    input  logic                clr_en_i,
    input  logic [AW-1:0]       clr_addr_i,
    input  logic [2:0][AW-1:0]  rd_addr_i,
    output logic [2:0]          rd_bit_o
);

    logic [NUM_REGS-1:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en_i) sb_d[clr_addr_i] = 1'b0;
        if (set_en_i) sb_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) sb_q <= '0;
        else         sb_q <= sb_d;
    end

    for (genvar p = 0; p < 3; p++) begin : g_rd
        assign rd_bit_o[p] = sb_q[rd_addr_i[p]];
    end

endmodule

// File: rtl/arm_decode_stage.sv
// ARM decode stage: splits fetched instructions into shifter/ALU fields,
// holds RAW hazards against a register scoreboard and registers one instruction for execute.
module arm_decode_stage #(
    parameter int NUM_REGS    = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr_in,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [3:0]             wb_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             cond,
    output logic [4:0]             opcode,
    output logic                   immediateOperand,
    output logic [1:0]             shiftType,
    output logic [3:0]             rotateVal,
    output logic [4:0]             rm_shift,
    output logic [7:0]             immediateVal,
    output logic [11:0]            immediateOffset,
    output logic [7:0]             rm_shiftSDT,
    output logic [3:0]             rn_addr,
    output logic [3:0]             rd_addr,
    output logic [3:0]             rm_addr,
    output logic                   set_flags,
    output logic                   is_load,
    output logic                   reg_write,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    import arm_decode_pkg::*;

    instr_class_e cls;
    dp_op_e       dp_op;
    dec_fields_t  dec_d, dec_q;
    logic         uses_rn, uses_rm, uses_rd;
    logic [3:0]   dest;
    logic [2:0]   sb_bits;
    logic         hazard, slot_free, issue, stall_inc;
    logic         out_valid_d, out_valid_q;
    logic [STALL_CNT_W-1:0] stall_d, stall_q;

    always_comb begin
        cls   = classify(instr_in);
        dp_op = dp_op_e'(instr_in[24:21]);
        dec_d = '0;
        dec_d.cond         = instr_in[31:28];
        dec_d.shift_type   = instr_in[6:5];
        dec_d.rotate_val   = instr_in[11:8];
        dec_d.rm_shift     = instr_in[11:7];
        dec_d.imm_val      = instr_in[7:0];
        dec_d.imm_off      = instr_in[11:0];
        dec_d.rm_shift_sdt = instr_in[11:4];
        dec_d.rn           = instr_in[19:16];
        dec_d.rd           = instr_in[15:12];
        dec_d.rm           = instr_in[3:0];
        uses_rn = 1'b0;
        uses_rm = 1'b0;
        uses_rd = 1'b0;
        dest    = instr_in[15:12];
        case (cls)
            CLS_DP: begin
                dec_d.opcode    = {1'b0, instr_in[24:21]};
                dec_d.imm_op    = instr_in[25];
                dec_d.set_flags = instr_in[20];
                dec_d.reg_write = !(dp_op inside {DP_TST, DP_TEQ, DP_CMP, DP_CMN});
                uses_rn         = !(dp_op inside {DP_MOV, DP_MVN});
                uses_rm         = ~instr_in[25];
            end
            CLS_LDST: begin
                dec_d.opcode    = OP_LDST;
                dec_d.imm_op    = ~instr_in[25];
                dec_d.is_load   = instr_in[20];
                dec_d.reg_write = instr_in[20];
                uses_rn         = 1'b1;
                uses_rm         = instr_in[25];
                // A store reads its data register, so rd is a source here.
                uses_rd         = ~instr_in[20];
            end
            CLS_BRANCH: begin
                dec_d.opcode    = OP_BRANCH;
                dec_d.reg_write = instr_in[24];
                dest            = REG_LR;
            end
            default: begin
                dec_d.opcode    = OP_UNDEF;
                uses_rn         = 1'b1;
            end
        endcase
    end

    arm_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk_i      (clk),
        .reset_i    (reset),
        .set_en_i   (issue && dec_d.reg_write && dest != REG_PC),
        .set_addr_i (dest),
        .clr_en_i   (wb_valid),
        .clr_addr_i (wb_addr),
        .rd_addr_i  ({dec_d.rd, dec_d.rm, dec_d.rn}),
        .rd_bit_o   (sb_bits)
    );

    // R15 reads the live PC, so it never waits on the scoreboard.
    assign hazard = (uses_rn && dec_d.rn != REG_PC && sb_bits[0])
                  | (uses_rm && dec_d.rm != REG_PC && sb_bits[1])
                  | (uses_rd && dec_d.rd != REG_PC && sb_bits[2]);

    assign slot_free   = ~out_valid_q | out_ready;
    assign instr_ready = ~reset & slot_free & ~hazard & ~flush;
    assign issue       = instr_valid & instr_ready;
    assign stall_inc   = instr_valid & slot_free & hazard & ~flush;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (issue)     out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        stall_d = stall_q;
        if (stall_inc && stall_q != '1) stall_d = stall_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            stall_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
            if (issue) dec_q <= dec_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign cond             = dec_q.cond;
    assign opcode           = dec_q.opcode;
    assign immediateOperand = dec_q.imm_op;
    assign shiftType        = dec_q.shift_type;
    assign rotateVal        = dec_q.rotate_val;
    assign rm_shift         = dec_q.rm_shift;
    assign immediateVal     = dec_q.imm_val;
    assign immediateOffset  = dec_q.imm_off;
    assign rm_shiftSDT      = dec_q.rm_shift_sdt;
    assign rn_addr          = dec_q.rn;
    assign rd_addr          = dec_q.rd;
    assign rm_addr          = dec_q.rm;
    assign set_flags        = dec_q.set_flags;
    assign is_load          = dec_q.is_load;
    assign reg_write        = dec_q.reg_write;
    assign stall_cycles     = stall_q;

endmodule
